// File: rtl/mul_arb.sv
// rtl/mul_arb.sv - two-port round-robin front end for a shared LAT-stage multiplier
// Optional perf counters: define MUL_ARB_PERFCNT_EN.
module mul_arb #(
  parameter int XLEN     = 64,
  parameter int LAT      = 1,
  parameter int RSPDEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Req0Valid,
  output logic              Req0Ready,
  input  logic [XLEN-1:0]   Req0A,
  input  logic [XLEN-1:0]   Req0B,
  input  logic [2:0]        Req0Funct3,
  output logic              Rsp0Valid,
  input  logic              Rsp0Ready,
  output logic [2*XLEN-1:0] Rsp0Prod,
  input  logic              Req1Valid,
  output logic              Req1Ready,
  input  logic [XLEN-1:0]   Req1A,
  input  logic [XLEN-1:0]   Req1B,
  input  logic [2:0]        Req1Funct3,
  output logic              Rsp1Valid,
  input  logic              Rsp1Ready,
  output logic [2*XLEN-1:0] Rsp1Prod,
  output logic [XLEN-1:0]   MulSrcA,
  output logic [XLEN-1:0]   MulSrcB,
  output logic [2:0]        MulFunct3,
  input  logic [2*XLEN-1:0] MulProdIn
`ifdef MUL_ARB_PERFCNT_EN
  ,
  output logic [31:0]       GrantCnt0,
  output logic [31:0]       GrantCnt1,
  output logic [31:0]       ConflictCnt
`endif
);

  localparam int CW = $clog2(RSPDEPTH + LAT + 1);
  localparam int PW = (RSPDEPTH > 1) ? $clog2(RSPDEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(RSPDEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(RSPDEPTH - 1);

  logic [1:0]        req_vld, rsp_rdy, credit, elig, gnt, push, pop;
  logic [CW-1:0]     infl_q [2];
  logic [CW-1:0]     occ_q [2];
  logic [PW-1:0]     wr_ptr_q [2];
  logic [PW-1:0]     rd_ptr_q [2];
  logic [2*XLEN-1:0] fifo_q [2][RSPDEPTH];
  logic [LAT-1:0]    pipe_vld_q, pipe_own_q;
  logic              rr_q;

  assign req_vld = {Req1Valid, Req0Valid};
  assign rsp_rdy = {Rsp1Ready, Rsp0Ready};

  // Credits come from registered counts only, so a pop frees its slot one cycle later.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      credit[i] = (infl_q[i] + occ_q[i]) < DEPTH_C;
      elig[i]   = reset & req_vld[i] & credit[i];
      push[i]   = pipe_vld_q[LAT-1] & (pipe_own_q[LAT-1] == 1'(i));
      pop[i]    = (occ_q[i] != '0) & rsp_rdy[i];
    end
    gnt[0] = elig[0] & (~elig[1] | ~rr_q);
    gnt[1] = elig[1] & ~gnt[0];
  end

  always_comb begin
    MulSrcA   = '0;
    MulSrcB   = '0;
    MulFunct3 = 3'b000;
    if (gnt[0]) begin
      MulSrcA   = Req0A;
      MulSrcB   = Req0B;
      MulFunct3 = Req0Funct3;
    end else if (gnt[1]) begin
      MulSrcA   = Req1A;
      MulSrcB   = Req1B;
      MulFunct3 = Req1Funct3;
    end
  end

  assign Req0Ready = gnt[0];
  assign Req1Ready = gnt[1];
  assign Rsp0Valid = occ_q[0] != '0;
  assign Rsp1Valid = occ_q[1] != '0;
  assign Rsp0Prod  = fifo_q[0][rd_ptr_q[0]];
  assign Rsp1Prod  = fifo_q[1][rd_ptr_q[1]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_vld_q <= '0;
      pipe_own_q <= '0;
      rr_q       <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        infl_q[i]   <= '0;
        occ_q[i]    <= '0;
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
    end else begin
      pipe_vld_q[0] <= |gnt;
      pipe_own_q[0] <= gnt[1];
      for (int k = 1; k < LAT; k++) begin
        pipe_vld_q[k] <= pipe_vld_q[k-1];
        pipe_own_q[k] <= pipe_own_q[k-1];
      end
      // rr_q=1 favours port 1; after a grant the other port gets priority.
      if (|gnt) rr_q <= gnt[0];
      for (int i = 0; i < 2; i++) begin
        infl_q[i] <= infl_q[i] + CW'(gnt[i]) - CW'(push[i]);
        occ_q[i]  <= occ_q[i] + CW'(push[i]) - CW'(pop[i]);
        if (push[i]) wr_ptr_q[i] <= (wr_ptr_q[i] == PTR_LAST) ? '0 : wr_ptr_q[i] + PW'(1);
        if (pop[i])  rd_ptr_q[i] <= (rd_ptr_q[i] == PTR_LAST) ? '0 : rd_ptr_q[i] + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) fifo_q[i][wr_ptr_q[i]] <= MulProdIn;
    end
  end

  a_ovf0: assert property (@(posedge clk) disable iff (!reset)
                           !(push[0] && (occ_q[0] == DEPTH_C) && !pop[0]));
  a_ovf1: assert property (@(posedge clk) disable iff (!reset)
                           !(push[1] && (occ_q[1] == DEPTH_C) && !pop[1]));

`ifdef MUL_ARB_PERFCNT_EN
  logic [31:0] gcnt0_q, gcnt1_q, ccnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gcnt0_q <= '0;
      gcnt1_q <= '0;
      ccnt_q  <= '0;
    end else begin
      if (gnt[0] && gcnt0_q != '1) gcnt0_q <= gcnt0_q + 32'd1;
      if (gnt[1] && gcnt1_q != '1) gcnt1_q <= gcnt1_q + 32'd1;
      if ((&req_vld) && (|gnt) && ccnt_q != '1) ccnt_q <= ccnt_q + 32'd1;
    end
  end

  assign GrantCnt0   = gcnt0_q;
  assign GrantCnt1   = gcnt1_q;
  assign ConflictCnt = ccnt_q;
`endif

endmodule

// File: tb/tb_mul_arb.sv
// tb/tb_mul_arb.sv - randomized and directed checks of mul_arb against a queue-based reference model
module tb_mul_arb;
  localparam int XLEN = 64;
  localparam int LAT  = 1;
  localparam int D    = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              Req0Valid = 1'b0, Req1Valid = 1'b0;
  logic              Req0Ready, Req1Ready;
  logic [XLEN-1:0]   Req0A = '0, Req0B = '0, Req1A = '0, Req1B = '0;
  logic [2:0]        Req0Funct3 = '0, Req1Funct3 = '0;
  logic              Rsp0Valid, Rsp1Valid;
  logic              Rsp0Ready = 1'b0, Rsp1Ready = 1'b0;
  logic [2*XLEN-1:0] Rsp0Prod, Rsp1Prod;
  logic [XLEN-1:0]   MulSrcA, MulSrcB;
  logic [2:0]        MulFunct3;
  logic [2*XLEN-1:0] MulProdIn;
`ifdef MUL_ARB_PERFCNT_EN
  logic [31:0]       GrantCnt0, GrantCnt1, ConflictCnt;
`endif

  always #5 clk = ~clk;

  mul_arb #(.XLEN(XLEN), .LAT(LAT), .RSPDEPTH(D)) dut (
    .clk(clk), .reset(reset),
    .Req0Valid(Req0Valid), .Req0Ready(Req0Ready), .Req0A(Req0A), .Req0B(Req0B),
    .Req0Funct3(Req0Funct3), .Rsp0Valid(Rsp0Valid), .Rsp0Ready(Rsp0Ready), .Rsp0Prod(Rsp0Prod),
    .Req1Valid(Req1Valid), .Req1Ready(Req1Ready), .Req1A(Req1A), .Req1B(Req1B),
    .Req1Funct3(Req1Funct3), .Rsp1Valid(Rsp1Valid), .Rsp1Ready(Rsp1Ready), .Rsp1Prod(Rsp1Prod),
    .MulSrcA(MulSrcA), .MulSrcB(MulSrcB), .MulFunct3(MulFunct3), .MulProdIn(MulProdIn)
`ifdef MUL_ARB_PERFCNT_EN
    , .GrantCnt0(GrantCnt0), .GrantCnt1(GrantCnt1), .ConflictCnt(ConflictCnt)
`endif
  );

  function automatic logic [127:0] mulf(input logic [63:0] a, input logic [63:0] b,
                                        input logic [2:0] f);
    logic [127:0] ea, eb;
    ea = (f == 3'b011) ? {64'b0, a} : {{64{a[63]}}, a};
    eb = (f == 3'b010 || f == 3'b011) ? {64'b0, b} : {{64{b[63]}}, b};
    return ea * eb;
  endfunction

  // Behavioural stand-in for the shared multiplier: LAT register stages.
  logic [127:0] mpipe [LAT];
  always @(posedge clk) begin
    mpipe[0] <= mulf(MulSrcA, MulSrcB, MulFunct3);
    for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
  end
  assign MulProdIn = mpipe[LAT-1];

  typedef struct {
    logic [127:0] p;
    int           t;
  } ent_t;

  ent_t q0[$];
  ent_t q1[$];
  logic ptr_m = 1'b0;
  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, predict from outstanding counts and RR pointer, compare, advance.
  task automatic step(input logic v0, input logic [63:0] a0, input logic [63:0] b0,
                      input logic [2:0] f0, input logic rr0,
                      input logic v1, input logic [63:0] a1, input logic [63:0] b1,
                      input logic [2:0] f1, input logic rr1,
                      output logic g0, output logic g1);
    logic e0, e1, ev;
    Req0Valid = v0; Req0A = a0; Req0B = b0; Req0Funct3 = f0; Rsp0Ready = rr0;
    Req1Valid = v1; Req1A = a1; Req1B = b1; Req1Funct3 = f1; Rsp1Ready = rr1;
    @(negedge clk);
    e0 = v0 && (q0.size() < D);
    e1 = v1 && (q1.size() < D);
    g0 = e0 && (!e1 || !ptr_m);
    g1 = e1 && !g0;
    chk("req0_ready", Req0Ready, g0);
    chk("req1_ready", Req1Ready, g1);
    chk("mul_a", MulSrcA, g0 ? a0 : (g1 ? a1 : 64'd0));
    chk("mul_b", MulSrcB, g0 ? b0 : (g1 ? b1 : 64'd0));
    chk("mul_f3", MulFunct3, g0 ? f0 : (g1 ? f1 : 3'd0));
    ev = (q0.size() > 0) && (q0[0].t <= cyc);
    chk("rsp0_valid", Rsp0Valid, ev);
    if (ev) begin
      chk("rsp0_prod", Rsp0Prod, q0[0].p);
      if (rr0) void'(q0.pop_front());
    end
    ev = (q1.size() > 0) && (q1[0].t <= cyc);
    chk("rsp1_valid", Rsp1Valid, ev);
    if (ev) begin
      chk("rsp1_prod", Rsp1Prod, q1[0].p);
      if (rr1) void'(q1.pop_front());
    end
    if (g0) q0.push_back('{p: mulf(a0, b0, f0), t: cyc + LAT + 1});
    if (g1) q1.push_back('{p: mulf(a1, b1, f1), t: cyc + LAT + 1});
    if (g0 || g1) ptr_m = g0;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input logic rr0, input logic rr1);
    logic g0, g1;
    step(1'b0, '0, '0, 3'd0, rr0, 1'b0, '0, '0, 3'd0, rr1, g0, g1);
  endtask

  task automatic do_rst(input int n);
    reset = 1'b0;
    Req0Valid = 1'b1; Req1Valid = 1'b1; Rsp0Ready = 1'b1; Rsp1Ready = 1'b1;
    q0.delete();
    q1.delete();
    ptr_m = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("rst_req0_ready", Req0Ready, 1'b0);
      chk("rst_req1_ready", Req1Ready, 1'b0);
      chk("rst_rsp0_valid", Rsp0Valid, 1'b0);
      chk("rst_rsp1_valid", Rsp1Valid, 1'b0);
      chk("rst_mul_a", MulSrcA, 64'd0);
      @(posedge clk);
      #1;
      cyc++;
    end
    reset = 1'b1;
    Req0Valid = 1'b0;
    Req1Valid = 1'b0;
  endtask

  initial begin
    logic g0, g1;
    logic hv0, hv1;
    logic [63:0] ha0, hb0, ha1, hb1;
    logic [2:0] hf0, hf1;
    int n0, n1;

    #1;
    do_rst(2);

    // Single op on port 0: 3*5 visible LAT+1 cycles after grant.
    step(1'b1, 64'd3, 64'd5, 3'b000, 1'b0, 1'b0, '0, '0, 3'd0, 1'b1, g0, g1);
    chk("t1_rsp0_early", Rsp0Valid, 1'b0);
    idle(1'b0, 1'b1);
    chk("t1_rsp0_valid", Rsp0Valid, 1'b1);
    chk("t1_rsp0_prod", Rsp0Prod, 128'd15);
    chk("t1_rsp1_valid", Rsp1Valid, 1'b0);
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b1);

    // Both valid from reset: alternation starting with port 0.
    do_rst(1);
    n0 = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 64'(i + 1), 64'd7, 3'b000, 1'b1, 1'b1, 64'(i + 100), 64'd9, 3'b011, 1'b1, g0, g1);
      if (i == 0) chk("t2_first_port0", g0, 1'b1);
      if (g0) n0++;
    end
    chk("t2_port0_share", n0, 4);
    repeat (3) idle(1'b1, 1'b1);

    // Port 1 consumer stalled: two credits, then port 1 blocked; then drain in order.
    do_rst(1);
    n1 = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 3'b001, 1'b1,
           1'b1, 64'(i + 40), 64'(i + 3), 3'b000, 1'b0, g0, g1);
      if (g1) n1++;
    end
    chk("t3_port1_grants", n1, 2);
    n1 = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, '0, '0, 3'd0, 1'b1, 1'b1, 64'(i + 60), 64'(i + 5), 3'b000, 1'b1, g0, g1);
      if (g1) n1++;
    end
    chk("t3_port1_resumed", n1 > 0, 1'b1);
    repeat (3) idle(1'b1, 1'b1);

    // Signed/unsigned high products of all-ones by 2.
    do_rst(1);
    step(1'b1, '1, 64'd2, 3'b001, 1'b0, 1'b0, '0, '0, 3'd0, 1'b1, g0, g1);
    idle(1'b0, 1'b1);
    chk("t4_mulh", Rsp0Prod, {{64{1'b1}}, 64'hFFFF_FFFF_FFFF_FFFE});
    idle(1'b1, 1'b1);
    step(1'b1, '1, 64'd2, 3'b011, 1'b0, 1'b0, '0, '0, 3'd0, 1'b1, g0, g1);
    idle(1'b0, 1'b1);
    chk("t4_mulhu", Rsp0Prod, {63'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE});
    idle(1'b1, 1'b1);

    // Reset with one op in the FIFO and one in flight: nothing stale afterwards.
    do_rst(1);
    step(1'b1, 64'd11, 64'd13, 3'b000, 1'b0, 1'b0, '0, '0, 3'd0, 1'b1, g0, g1);
    step(1'b1, 64'd17, 64'd19, 3'b000, 1'b0, 1'b0, '0, '0, 3'd0, 1'b1, g0, g1);
    chk("t5_fifo_loaded", Rsp0Valid, 1'b1);
    do_rst(2);
    chk("t5_after_rst", Rsp0Valid, 1'b0);
    repeat (4) idle(1'b1, 1'b1);

    // Randomized traffic with request hold while valid and not ready.
    do_rst(1);
    hv0 = 1'b0; hv1 = 1'b0; g0 = 1'b0; g1 = 1'b0;
    ha0 = '0; hb0 = '0; ha1 = '0; hb1 = '0; hf0 = '0; hf1 = '0;
    for (int i = 0; i < 400; i++) begin
      if (!hv0 || g0) begin
        hv0 = ($urandom_range(0, 3) != 0);
        ha0 = {$urandom, $urandom}; hb0 = {$urandom, $urandom};
        hf0 = 3'($urandom_range(0, 3));
      end
      if (!hv1 || g1) begin
        hv1 = ($urandom_range(0, 3) != 0);
        ha1 = {$urandom, $urandom}; hb1 = {$urandom, $urandom};
        hf1 = 3'($urandom_range(0, 3));
      end
      step(hv0, ha0, hb0, hf0, ($urandom_range(0, 3) != 0),
           hv1, ha1, hb1, hf1, ($urandom_range(0, 2) != 0), g0, g1);
    end
    repeat (4) idle(1'b1, 1'b1);

`ifdef MUL_ARB_PERFCNT_EN
    do_rst(1);
    for (int i = 0; i < 10; i++)
      step(1'b1, 64'(i), 64'd3, 3'b000, 1'b1, 1'b1, 64'(i), 64'd5, 3'b000, 1'b1, g0, g1);
    chk("t6_grant0", GrantCnt0, 32'd5);
    chk("t6_grant1", GrantCnt1, 32'd5);
    chk("t6_conflict", ConflictCnt, 32'd10);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
